// File: rtl/fp_norm_sched_if.sv
// rtl/fp_norm_sched_if.sv - operand and result handshake bundle for the FP normalisation sequencer
//
// Purpose : groups the two producer channels (A = multiplier product, B = accumulator
//           sum) and the result channel towards the pack/round stage.
// Modports: master - producer/consumer side (drives operands and out_ready)
//           slave  - normaliser side (drives a_ready/b_ready and all out_*)
// Signals : a_valid/a_ready/a_sign/a_exp/a_mant  requester A operand channel
//           b_valid/b_ready/b_sign/b_exp/b_mant  requester B operand channel
//           out_valid/out_ready/out_sign/out_exp/out_mant/out_src/out_zero/out_uflow
//                                                 normalised result channel
interface fp_norm_sched_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic              a_valid;
  logic              a_ready;
  logic              a_sign;
  logic [EXP_W-1:0]  a_exp;
  logic [MANT_W-1:0] a_mant;

  logic              b_valid;
  logic              b_ready;
  logic              b_sign;
  logic [EXP_W-1:0]  b_exp;
  logic [MANT_W-1:0] b_mant;

  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_src;
  logic              out_zero;
  logic              out_uflow;

  modport master (
    output a_valid, a_sign, a_exp, a_mant,
    input  a_ready,
    output b_valid, b_sign, b_exp, b_mant,
    input  b_ready,
    input  out_valid, out_sign, out_exp, out_mant, out_src, out_zero, out_uflow,
    output out_ready
  );

  modport slave (
    input  a_valid, a_sign, a_exp, a_mant,
    output a_ready,
    input  b_valid, b_sign, b_exp, b_mant,
    output b_ready,
    output out_valid, out_sign, out_exp, out_mant, out_src, out_zero, out_uflow,
    input  out_ready
  );
endinterface

// File: rtl/fp_norm_sched.sv
// rtl/fp_norm_sched.sv - round-robin shared normaliser for the FP MAC (leading-one detect + shift)
//
// Purpose : arbitrates between requester A (product path) and B (sum path), finds the
//           leading one of the captured mantissa, left-shifts it to bit MANT_W-1,
//           adjusts the exponent and presents the result with a valid/ready handshake.
//           One job takes IDLE -> DETECT -> SHIFT -> DONE; result visible 3 cycles after
//           the accepting cycle.
// Ports   : i_clock - rising-edge clock
//           i_reset - synchronous active-high reset, aborts any job in flight
//           bus     - fp_norm_sched_if.slave operand/result channels
module fp_norm_sched #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic           i_clock,
  input  logic           i_reset,
  fp_norm_sched_if.slave bus
);

  localparam int CMP_W = (EXP_W > CNT_W) ? EXP_W : CNT_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DETECT = 2'd1,
    S_SHIFT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_rr_ptr;   // 1: B wins a tie (A was served last)
  logic              r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant;
  logic              r_src;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_out_valid;
  logic              r_out_sign;
  logic [EXP_W-1:0]  r_out_exp;
  logic [MANT_W-1:0] r_out_mant;
  logic              r_out_src;
  logic              r_out_zero;
  logic              r_out_uflow;

  logic              w_idle;
  logic              w_grant_b;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_accept;
  logic [CNT_W-1:0]  w_lod;
  logic [CNT_W-1:0]  w_shamt;
  logic              w_exp_gt_s;
  logic [MANT_W-1:0] w_shifted;
  logic [EXP_W-1:0]  w_exp_adj;

  // Readies are gated by reset so nothing is accepted while reset is held,
  // even once the state register already reads IDLE.
  assign w_idle    = (r_state == S_IDLE) && !i_reset;
  assign w_grant_b = bus.b_valid && (!bus.a_valid || r_rr_ptr);
  assign w_a_ready = w_idle && bus.a_valid && !w_grant_b;
  assign w_b_ready = w_idle && w_grant_b;
  assign w_accept  = w_a_ready || w_b_ready;

  // Highest set bit wins because later iterations overwrite earlier ones.
  // An all-zero mantissa leaves the default of MANT_W-1 (shift of zero).
  always_comb begin
    w_lod = CNT_W'(MANT_W - 1);
    for (int i = 0; i < MANT_W; i++) begin
      if (r_mant[i]) begin
        w_lod = CNT_W'(i);
      end
    end
  end

  assign w_shamt    = CNT_W'(MANT_W - 1) - r_cnt;
  // Compared at a common width so the test never wraps, whichever of EXP_W/CNT_W is wider.
  assign w_exp_gt_s = CMP_W'(r_exp) > CMP_W'(w_shamt);
  assign w_shifted  = r_mant << w_shamt;
  assign w_exp_adj  = r_exp - EXP_W'(w_shamt);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_src       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_mant  <= '0;
      r_out_src   <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_uflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign   <= w_grant_b ? bus.b_sign : bus.a_sign;
            r_exp    <= w_grant_b ? bus.b_exp  : bus.a_exp;
            r_mant   <= w_grant_b ? bus.b_mant : bus.a_mant;
            r_src    <= w_grant_b;
            r_rr_ptr <= !w_grant_b;
            r_state  <= S_DETECT;
          end
        end

        S_DETECT: begin
          r_cnt   <= w_lod;
          r_state <= S_SHIFT;
        end

        S_SHIFT: begin
          r_out_sign  <= r_sign;
          r_out_src   <= r_src;
          r_out_valid <= 1'b1;
          if (r_mant == '0) begin
            r_out_zero  <= 1'b1;
            r_out_uflow <= 1'b0;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
          end else if (w_exp_gt_s) begin
            r_out_zero  <= 1'b0;
            r_out_uflow <= 1'b0;
            r_out_mant  <= w_shifted;
            r_out_exp   <= w_exp_adj;
          end else begin
            // Exponent cannot absorb the shift: flush to zero and flag it.
            r_out_zero  <= 1'b0;
            r_out_uflow <= 1'b1;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_b_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sign  = r_out_sign;
  assign bus.out_exp   = r_out_exp;
  assign bus.out_mant  = r_out_mant;
  assign bus.out_src   = r_out_src;
  assign bus.out_zero  = r_out_zero;
  assign bus.out_uflow = r_out_uflow;

endmodule

// File: tb/tb_fp_norm_sched.sv
// tb/tb_fp_norm_sched.sv - self-checking bench for fp_norm_sched
module tb_fp_norm_sched;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        src;
    logic        zero;
    logic        uflow;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   pref_b = 1'b0;
  int   last_wait = 0;

  fp_norm_sched_if bus ();

  fp_norm_sched dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t ref_norm(input logic sign, input logic [7:0] e,
                                    input logic [23:0] m, input logic src);
    res_t r;
    int   msb;
    int   s;
    r      = '0;
    r.sign = sign;
    r.src  = src;
    if (m == 24'd0) begin
      r.zero = 1'b1;
    end else begin
      msb = $clog2(int'(m) + 1) - 1;   // floor(log2(m))
      s   = 23 - msb;
      if (int'(e) > s) begin
        r.mant = m << s;
        r.exp  = 8'(int'(e) - s);
      end else begin
        r.uflow = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input res_t e);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_sign"},  32'(bus.out_sign),  32'(e.sign));
    check({tag, "_exp"},   32'(bus.out_exp),   32'(e.exp));
    check({tag, "_mant"},  32'(bus.out_mant),  32'(e.mant));
    check({tag, "_src"},   32'(bus.out_src),   32'(e.src));
    check({tag, "_zero"},  32'(bus.out_zero),  32'(e.zero));
    check({tag, "_uflow"}, 32'(bus.out_uflow), 32'(e.uflow));
  endtask

  // One job: present valids, wait for a grant, then follow the result through
  // latency, optional backpressure (bp cycles of out_ready=0) and release.
  task automatic job(input bit av, input bit bv, input int bp, input bit hold, input string tag);
    res_t e;
    bit   ga;
    int   w;
    bus.a_valid   = av;
    bus.b_valid   = bv;
    bus.out_ready = (bp == 0);
    #1;
    ga = av && (!bv || !pref_b);
    w  = 0;
    while (!(bus.a_ready || bus.b_ready) && w < 12) begin
      tick();
      w++;
    end
    last_wait = w;
    check({tag, "_accept"}, 32'(w < 12), 32'd1);
    check({tag, "_a_ready"}, 32'(bus.a_ready), 32'(ga));
    check({tag, "_b_ready"}, 32'(bus.b_ready), 32'(!ga));
    e = ga ? ref_norm(bus.a_sign, bus.a_exp, bus.a_mant, 1'b0)
           : ref_norm(bus.b_sign, bus.b_exp, bus.b_mant, 1'b1);
    pref_b = ga;

    tick();  // C+1
    if (!hold) begin
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      #1;
    end
    check({tag, "_c1_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_c1_busy"},  32'(bus.a_ready || bus.b_ready), 32'd0);
    tick();  // C+2
    check({tag, "_c2_valid"}, 32'(bus.out_valid), 32'd0);
    tick();  // C+3
    check_out(tag, e);
    for (int i = 0; i < bp; i++) begin
      tick();
      check_out({tag, "_bp"}, e);
      check({tag, "_bp_busy"}, 32'(bus.a_ready || bus.b_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic set_a(input logic s, input logic [7:0] e, input logic [23:0] m);
    bus.a_sign = s;
    bus.a_exp  = e;
    bus.a_mant = m;
  endtask

  task automatic set_b(input logic s, input logic [7:0] e, input logic [23:0] m);
    bus.b_sign = s;
    bus.b_exp  = e;
    bus.b_mant = m;
  endtask

  initial begin
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.out_ready = 1'b1;
    set_a(1'b0, 8'd0, 24'd0);
    set_b(1'b0, 8'd0, 24'd0);

    // Reset held two cycles with a_valid asserted.
    rst = 1'b1;
    bus.a_valid = 1'b1;
    set_a(1'b0, 8'd130, 24'h004000);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_a_ready",   32'(bus.a_ready),   32'd0);
      check("rst_b_ready",   32'(bus.b_ready),   32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_bus",   32'({bus.out_sign, bus.out_exp, bus.out_mant,
                                  bus.out_src, bus.out_zero, bus.out_uflow} != '0), 32'd0);
    end
    bus.a_valid = 1'b0;
    rst = 1'b0;
    pref_b = 1'b0;
    tick();

    // Arbitration from reset: both valid held for three jobs -> A, B, A.
    set_a(1'b0, 8'd100, 24'h000F00);
    set_b(1'b1, 8'd50,  24'h3A0000);
    job(1'b1, 1'b1, 0, 1'b1, "arb0");
    check("arb0_src", 32'(bus.out_src), 32'd0);
    job(1'b1, 1'b1, 0, 1'b1, "arb1");
    check("arb1_src", 32'(bus.out_src), 32'd1);
    job(1'b1, 1'b1, 0, 1'b0, "arb2");
    check("arb2_src", 32'(bus.out_src), 32'd0);

    // A only, known answer.
    set_a(1'b0, 8'd130, 24'h004000);
    job(1'b1, 1'b0, 0, 1'b0, "a_only");
    check("a_only_mant_k", 32'(bus.out_mant), 32'h800000);
    check("a_only_exp_k",  32'(bus.out_exp),  32'd121);

    // Zero operand on B.
    set_b(1'b1, 8'd90, 24'd0);
    job(1'b0, 1'b1, 0, 1'b0, "zero_b");
    check("zero_b_flag_k", 32'(bus.out_zero), 32'd1);

    // Underflow on A (s = 19 >= exp = 3), and exp==0 boundary, and exp==s boundary.
    set_a(1'b0, 8'd3, 24'h000010);
    job(1'b1, 1'b0, 0, 1'b0, "uflow");
    check("uflow_flag_k", 32'(bus.out_uflow), 32'd1);
    set_a(1'b1, 8'd0, 24'h800000);
    job(1'b1, 1'b0, 0, 1'b0, "exp0");
    set_a(1'b0, 8'd19, 24'h000010);
    job(1'b1, 1'b0, 0, 1'b0, "exp_eq_s");
    set_a(1'b0, 8'd20, 24'h000010);
    job(1'b1, 1'b0, 0, 1'b0, "exp_s_plus1");
    set_b(1'b0, 8'd255, 24'h000001);
    job(1'b0, 1'b1, 0, 1'b0, "lsb_only");

    // Backpressure: out_ready low 5 cycles while B also waits.
    set_a(1'b1, 8'd200, 24'h0ABCDE);
    set_b(1'b0, 8'd77,  24'h000321);
    bus.b_valid = 1'b1;
    job(1'b1, 1'b1, 5, 1'b1, "bp");
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();

    // Abort: A accepted (would make B preferred), reset during DETECT.
    set_a(1'b0, 8'd100, 24'h000123);
    bus.a_valid   = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("abort_accept", 32'(bus.a_ready), 32'd1);
    tick();  // DETECT
    bus.a_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("abort_rst_valid", 32'(bus.out_valid), 32'd0);
    check("abort_rst_ready", 32'(bus.a_ready || bus.b_ready), 32'd0);
    rst = 1'b0;
    pref_b = 1'b0;
    set_b(1'b1, 8'd60, 24'h00FFFF);
    job(1'b1, 1'b1, 0, 1'b0, "post_abort");
    check("post_abort_wait", 32'(last_wait), 32'd0);
    check("post_abort_src",  32'(bus.out_src), 32'd0);

    // Randomised jobs against the reference model.
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(1, 3);
      set_a(1'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 24) : $urandom_range(0, 255)),
            24'($urandom) >> $urandom_range(0, 24));
      set_b(1'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 24) : $urandom_range(0, 255)),
            24'($urandom) >> $urandom_range(0, 24));
      job(r[0], r[1], $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
